audio_adc_deserializer: RTL and testbench
=========================================

# audio_adc_deserializer

Parametrised stereo audio ADC serial receiver, clocked directly by the codec bit clock. It supports left-justified and I2S framing, configurable sample and slot width, and LR polarity. Each complete {left, right} sample pair is pushed into the downstream dual-clock FIFO write port with a single-cycle request. It also reports FIFO overflows and malformed (short) slots, and sits between the codec ADC pins and the sample FIFO that feeds the visualiser pipeline.

## Interface
- DATA_WIDTH, 16: captured bits per channel, MSB first; legal 8..32.
- SLOT_WIDTH, 32: BCLK periods per channel slot; legal range DATA_WIDTH+1..64.
- MODE, 0: 0 = left-justified (MSB on the first BCLK of the slot), 1 = I2S (MSB one BCLK later).
- LEFT_HIGH, 1: 1 = AUD_ADC_CLK high denotes the left channel.
- AUD_BCLK  in  1  sole clock; all logic samples on the rising edge.
- RESET_N  in  1  reset, asynchronous, active-low.
- enable  in  1  capture enable.
- clear  in  1  synchronous clear of overflow_cnt and frame_err.
- AUD_ADC_CLK  in  1  LR clock.
- AUD_ADC_DATA  in  1  serial data.
- wrfull_sig  in  1  FIFO full.
- wrreq_sig  out  1  FIFO write request, one-cycle pulse.
- data_sig  out  2*DATA_WIDTH  {left, right}, left in the MSBs.
- overflow_cnt  out  8  frames dropped because the FIFO was full; saturating.
- frame_err  out  1  sticky short-slot flag.

## Operation
- lrck_q registers AUD_ADC_CLK every cycle, regardless of state.
- A transition is a cycle where AUD_ADC_CLK != lrck_q. The new channel is the sampled AUD_ADC_CLK value, interpreted via LEFT_HIGH.
- Slot position p:
  - p = 0 on a transition cycle, otherwise p+1.
  - p saturates at SLOT_WIDTH.
- Bit index k = p − MODE.
  - When 0 ≤ k < DATA_WIDTH, AUD_ADC_DATA is written to bit DATA_WIDTH−1−k of the current channel's shift word.
  - Bits beyond that are ignored.
- A channel word completes on the cycle k = DATA_WIDTH−1 is captured.
  - Left completion copies the word to left_hold and sets left_valid.
- A right completion with left_valid = 1 is a frame:
  - wrfull_sig = 0: load data_sig = {left_hold, right word}, assert wrreq_sig.
  - wrfull_sig = 1: no write, data_sig unchanged, overflow_cnt increments (saturates at 255).
  - In both cases left_valid clears.
- A right completion with left_valid = 0 (partial first frame) is discarded silently.
- Short slot: a transition arriving while the outgoing channel's word is incomplete (k < DATA_WIDTH−1 at the previous cycle) sets frame_err. The partial word is discarded, and for a short left slot left_valid is cleared.
- State machine:
  - IDLE (enable = 0): no capture, left_valid = 0, wrreq_sig = 0. Exits to SYNC when enable = 1.
  - SYNC: waits for the next transition, which moves it to RUN. That transition cycle is processed as p = 0 of the new slot.
  - RUN: normal capture. Returns to IDLE when enable = 0; any partial frame is dropped.
- clear = 1 zeros overflow_cnt and frame_err. clear wins over a same-cycle increment or set.

## Timing
- Reset values: wrreq_sig = 0, data_sig = 0, overflow_cnt = 0, frame_err = 0, state IDLE, left_valid = 0, lrck_q = 0.
- Reset is asynchronous mid-frame; capture resumes through SYNC, so the first push is a complete frame.
- wrreq_sig and data_sig are registered at the edge that samples the final right-channel bit.
  - wrreq_sig is high for exactly one BCLK period.
  - data_sig holds until the next push.
- wrfull_sig is sampled at the right-completion edge only.
- Latency from the last right-channel bit to wrreq_sig high: 1 rising edge.
- Minimum spacing between pushes: 2*SLOT_WIDTH cycles.
- frame_err and overflow_cnt update on the edge after their cause.

## Test plan
- LJ, defaults: left = 0xA5C3, right = 0x1234, LEFT_HIGH = 1, 32-BCLK slots -> one wrreq_sig pulse, data_sig = 0xA5C31234, no further pulse until the next frame.
- MODE = 1 (I2S), same words with the 1-BCLK MSB delay -> data_sig = 0xA5C31234. The same stream sent with MODE = 0 framing -> a different value, proving the offset.
- wrfull_sig held high for 300 frames -> wrreq_sig never asserts, overflow_cnt = 255 saturated. Then clear -> 0, and the next frame after wrfull_sig drops pushes normally.
- One left slot shortened to 12 BCLKs -> frame_err = 1, that frame produces no push, the following good frame pushes correctly. frame_err stays 1 until clear.
- enable raised mid-left slot, or RESET_N pulsed mid-right slot -> no push for the partial frame; the first wrreq_sig carries the first complete left/right pair.
- DATA_WIDTH = 24, SLOT_WIDTH = 32, LEFT_HIGH = 0: left = 0x800001, right = 0x7FFFFE -> data_sig = 0x8000017FFFFE.

Source files
------------

// File: rtl/audio_adc_deserializer_if.sv
// Sample-pair write port between the ADC deserializer and the dual-clock sample FIFO.
// Latency: n/a (wires only).
// Backpressure: wrfull_sig from the FIFO; a push attempted while full is dropped by the master.
// Ports: wrreq_sig (one-cycle write strobe), data_sig ({left, right}), wrfull_sig (FIFO full).
interface audio_adc_deserializer_if #(
    parameter int DATA_WIDTH = 16
) ();
    logic                      wrreq_sig;
    logic [2*DATA_WIDTH-1:0]   data_sig;
    logic                      wrfull_sig;

    modport master (
        output wrreq_sig,
        output data_sig,
        input  wrfull_sig
    );

    modport slave (
        input  wrreq_sig,
        input  data_sig,
        output wrfull_sig
    );
endinterface

// File: rtl/audio_adc_deserializer.sv
// Stereo codec ADC serial receiver (LJ / I2S) pushing {left, right} pairs into the sample FIFO.
// Latency: wrreq_sig/data_sig registered on the edge that samples the last right-channel bit.
// Backpressure: none upstream; a frame completing while wrfull_sig is high is dropped and counted.
// Ports: AUD_BCLK (sole clock), RESET_N (async, active-low), enable, clear (zeros overflow_cnt /
//        frame_err), AUD_ADC_CLK / AUD_ADC_DATA (codec pins), fifo (write port, master side),
//        overflow_cnt (saturating dropped-frame count), frame_err (sticky short-slot flag).
module audio_adc_deserializer #(
    parameter int DATA_WIDTH = 16,
    parameter int SLOT_WIDTH = 32,
    parameter int MODE       = 0,
    parameter int LEFT_HIGH  = 1
) (
    input  logic                       AUD_BCLK,
    input  logic                       RESET_N,
    input  logic                       enable,
    input  logic                       clear,
    input  logic                       AUD_ADC_CLK,
    input  logic                       AUD_ADC_DATA,
    audio_adc_deserializer_if.master   fifo,
    output logic [7:0]                 overflow_cnt,
    output logic                       frame_err
);

    localparam int PW = $clog2(SLOT_WIDTH + 1);
    localparam logic [PW-1:0] P_MAX = PW'(SLOT_WIDTH);
    localparam logic [PW-1:0] P_ONE = PW'(1);

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        RUN
    } state_t;

    state_t                   state_q;
    state_t                   state_d;

    logic                     lrck_q;
    logic                     trans;
    logic                     new_left;
    logic [PW-1:0]            p_q;
    logic [PW-1:0]            pos;
    logic                     ch_left_q;
    logic                     cur_left;
    int                       kpos;
    logic                     bit_vld;
    logic                     word_done;
    logic                     cap;
    logic                     chk_short;
    logic                     short_slot;
    logic                     frame_done;

    logic [DATA_WIDTH-1:0]    shift_word;
    logic [DATA_WIDTH-1:0]    word_now;
    logic [DATA_WIDTH-1:0]    left_hold;
    logic                     left_valid;
    logic                     wrreq_q;
    logic [2*DATA_WIDTH-1:0]  data_q;
    logic [7:0]               ovf_q;
    logic                     ferr_q;

    assign fifo.wrreq_sig = wrreq_q;
    assign fifo.data_sig  = data_q;
    assign overflow_cnt   = ovf_q;
    assign frame_err      = ferr_q;

    // Slot tracking runs regardless of FSM state so SYNC sees a clean edge.
    always_comb begin
        trans    = (AUD_ADC_CLK != lrck_q);
        new_left = (AUD_ADC_CLK == LEFT_HIGH[0]);
        if (trans) begin
            pos = '0;
        end else if (p_q == P_MAX) begin
            pos = p_q;
        end else begin
            pos = p_q + P_ONE;
        end
        cur_left  = trans ? new_left : ch_left_q;
        kpos      = int'(pos) - MODE;
        bit_vld   = (kpos >= 0) && (kpos < DATA_WIDTH);
        word_done = bit_vld && (kpos == DATA_WIDTH - 1);
        // Bits arrive MSB first, so shifting left places bit k at DATA_WIDTH-1-k.
        word_now  = {shift_word[DATA_WIDTH-2:0], AUD_ADC_DATA};
    end

    // FSM next-state and per-cycle qualifiers.
    always_comb begin
        state_d   = state_q;
        cap       = 1'b0;
        chk_short = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = SYNC;
                end
            end
            SYNC: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (trans) begin
                    // The aligning edge is itself position 0 of the new slot.
                    state_d = RUN;
                    cap     = 1'b1;
                end
            end
            RUN: begin
                if (!enable) begin
                    state_d = IDLE;
                end else begin
                    cap       = 1'b1;
                    chk_short = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The outgoing slot is short if its last position never reached the final data bit.
    assign short_slot = chk_short && trans && (int'(p_q) < DATA_WIDTH - 1 + MODE);
    assign frame_done = cap && word_done && !cur_left && left_valid;

    always_ff @(posedge AUD_BCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge AUD_BCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            lrck_q     <= 1'b0;
            p_q        <= '0;
            ch_left_q  <= 1'b0;
            shift_word <= '0;
            left_hold  <= '0;
            left_valid <= 1'b0;
            wrreq_q    <= 1'b0;
            data_q     <= '0;
            ovf_q      <= '0;
            ferr_q     <= 1'b0;
        end else begin
            lrck_q    <= AUD_ADC_CLK;
            p_q       <= pos;
            ch_left_q <= cur_left;
            wrreq_q   <= 1'b0;

            if (cap && bit_vld) begin
                shift_word <= word_now;
            end

            if (!enable) begin
                left_valid <= 1'b0;
            end else if (cap) begin
                if (short_slot && ch_left_q) begin
                    left_valid <= 1'b0;
                end else if (word_done && cur_left) begin
                    left_hold  <= word_now;
                    left_valid <= 1'b1;
                end else if (word_done) begin
                    // Any right completion closes the pair, pushed or not.
                    left_valid <= 1'b0;
                end
            end

            if (frame_done && !fifo.wrfull_sig) begin
                wrreq_q <= 1'b1;
                data_q  <= {left_hold, word_now};
            end

            if (clear) begin
                ovf_q <= '0;
            end else if (frame_done && fifo.wrfull_sig && (ovf_q != 8'hFF)) begin
                ovf_q <= ovf_q + 8'd1;
            end

            if (clear) begin
                ferr_q <= 1'b0;
            end else if (short_slot) begin
                ferr_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_audio_adc_deserializer.sv
// Bench for audio_adc_deserializer: three instances (LJ/16, I2S/16 on shared pins, LJ/24 LEFT_LOW).
// Latency: expected pairs are queued before the right slot is driven and popped on each wrreq_sig.
// Backpressure: wrfull_sig driven by the bench to exercise drop/overflow counting.
module tb_audio_adc_deserializer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] lrck;
    logic [1:0] sdat;
    logic [1:0] en;
    logic [1:0] clr;
    logic [1:0] full;

    logic [7:0] ovf0, ovf1, ovf2;
    logic       ferr0, ferr1, ferr2;

    int nvec  = 0;
    int nmiss = 0;

    logic [63:0] q0[$];
    logic [63:0] q1[$];
    logic [63:0] q2[$];
    logic [63:0] e0, e1, e2;

    always #5 clk = ~clk;

    audio_adc_deserializer_if #(.DATA_WIDTH(16)) if0 ();
    audio_adc_deserializer_if #(.DATA_WIDTH(16)) if1 ();
    audio_adc_deserializer_if #(.DATA_WIDTH(24)) if2 ();

    assign if0.wrfull_sig = full[0];
    assign if1.wrfull_sig = full[0];
    assign if2.wrfull_sig = full[1];

    audio_adc_deserializer #(.DATA_WIDTH(16), .SLOT_WIDTH(32), .MODE(0), .LEFT_HIGH(1)) dut0 (
        .AUD_BCLK(clk), .RESET_N(rst_n), .enable(en[0]), .clear(clr[0]),
        .AUD_ADC_CLK(lrck[0]), .AUD_ADC_DATA(sdat[0]), .fifo(if0),
        .overflow_cnt(ovf0), .frame_err(ferr0));

    audio_adc_deserializer #(.DATA_WIDTH(16), .SLOT_WIDTH(32), .MODE(1), .LEFT_HIGH(1)) dut1 (
        .AUD_BCLK(clk), .RESET_N(rst_n), .enable(en[0]), .clear(clr[0]),
        .AUD_ADC_CLK(lrck[0]), .AUD_ADC_DATA(sdat[0]), .fifo(if1),
        .overflow_cnt(ovf1), .frame_err(ferr1));

    audio_adc_deserializer #(.DATA_WIDTH(24), .SLOT_WIDTH(32), .MODE(0), .LEFT_HIGH(0)) dut2 (
        .AUD_BCLK(clk), .RESET_N(rst_n), .enable(en[1]), .clear(clr[1]),
        .AUD_ADC_CLK(lrck[1]), .AUD_ADC_DATA(sdat[1]), .fifo(if2),
        .overflow_cnt(ovf2), .frame_err(ferr2));

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        if (obs !== exp) begin
            nmiss++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Serial slot image: bit p is what the codec drives at slot position p.
    function automatic logic [63:0] build(input logic [31:0] w, input int f, input int dw);
        logic [63:0] b;
        b = '0;
        for (int p = 0; p < 64; p++) begin
            int k;
            k = p - f;
            if (k >= 0 && k < dw) b[p] = w[dw-1-k];
        end
        return b;
    endfunction

    // What a receiver with the given MSB offset reads out of a slot image.
    function automatic logic [31:0] capture(input logic [63:0] bits, input int mode, input int dw);
        logic [31:0] w;
        w = '0;
        for (int k = 0; k < dw; k++) w[dw-1-k] = bits[k+mode];
        return w;
    endfunction

    task automatic send_slot(input int s, input bit is_left, input logic [63:0] bits,
                             input int len, input int en_at, input int rst_at);
        bit lh;
        lh = (s == 0);
        for (int p = 0; p < len; p++) begin
            @(negedge clk);
            lrck[s] = is_left ? lh : ~lh;
            sdat[s] = bits[p];
            if (p == en_at) en[s] = 1'b1;
            if (p == rst_at) begin
                rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
        end
    endtask

    task automatic send_frame(input int s, input logic [31:0] l, input logic [31:0] r,
                              input int f, input bit push, input int left_len,
                              input int en_at, input int rst_at);
        int dw;
        logic [63:0] bl, br;
        logic [31:0] cl, cr;
        dw = (s == 0) ? 16 : 24;
        bl = build(l, f, dw);
        br = build(r, f, dw);
        if (push) begin
            if (s == 0) begin
                cl = capture(bl, 0, 16);
                cr = capture(br, 0, 16);
                q0.push_back({32'd0, cl[15:0], cr[15:0]});
                cl = capture(bl, 1, 16);
                cr = capture(br, 1, 16);
                q1.push_back({32'd0, cl[15:0], cr[15:0]});
            end else begin
                cl = capture(bl, 0, 24);
                cr = capture(br, 0, 24);
                q2.push_back({16'd0, cl[23:0], cr[23:0]});
            end
        end
        send_slot(s, 1'b1, bl, left_len, en_at, -1);
        send_slot(s, 1'b0, br, 32, -1, rst_at);
    endtask

    // Scoreboard side: every cycle with wrreq_sig high must match the oldest queued pair.
    always @(negedge clk) begin
        if (if0.wrreq_sig === 1'b1) begin
            if (q0.size() == 0) check_eq("dut0_unexpected_push", {63'd0, if0.wrreq_sig}, 64'd0);
            else begin
                e0 = q0.pop_front();
                check_eq("dut0_data", {32'd0, if0.data_sig}, e0);
            end
        end
        if (if1.wrreq_sig === 1'b1) begin
            if (q1.size() == 0) check_eq("dut1_unexpected_push", {63'd0, if1.wrreq_sig}, 64'd0);
            else begin
                e1 = q1.pop_front();
                check_eq("dut1_data", {32'd0, if1.data_sig}, e1);
            end
        end
        if (if2.wrreq_sig === 1'b1) begin
            if (q2.size() == 0) check_eq("dut2_unexpected_push", {63'd0, if2.wrreq_sig}, 64'd0);
            else begin
                e2 = q2.pop_front();
                check_eq("dut2_data", {16'd0, if2.data_sig}, e2);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        lrck  = 2'b10;   // both pin sets parked at their right-channel level
        sdat  = 2'b00;
        en    = 2'b00;
        clr   = 2'b00;
        full  = 2'b00;

        repeat (3) @(negedge clk);
        check_eq("rst_wrreq", {63'd0, if0.wrreq_sig}, 64'd0);
        check_eq("rst_data", {32'd0, if0.data_sig}, 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("rst_ovf", {56'd0, ovf0}, 64'd0);
        check_eq("rst_ferr", {63'd0, ferr0}, 64'd0);
        check_eq("rst_data2", {16'd0, if2.data_sig}, 64'd0);

        // Left-justified pairs; the I2S instance sees the same pins one bit early.
        en[0] = 1'b1;
        send_frame(0, 32'hA5C3, 32'h1234, 0, 1'b1, 32, -1, -1);
        send_frame(0, 32'h0001, 32'hFFFF, 0, 1'b1, 32, -1, -1);
        repeat (40) @(negedge clk);

        // I2S framing: the MODE=1 instance gets the words exactly, MODE=0 reads a shifted value.
        send_frame(0, 32'hA5C3, 32'h1234, 1, 1'b1, 32, -1, -1);
        send_frame(0, 32'h8001, 32'h7FFE, 1, 1'b1, 32, -1, -1);

        // FIFO full for 300 frames: no pushes, counter saturates.
        full[0] = 1'b1;
        for (int i = 0; i < 300; i++) begin
            send_frame(0, $urandom, $urandom, 0, 1'b0, 32, -1, -1);
        end
        check_eq("ovf0_sat", {56'd0, ovf0}, 64'd255);
        check_eq("ovf1_sat", {56'd0, ovf1}, 64'd255);
        check_eq("ferr0_clean", {63'd0, ferr0}, 64'd0);
        @(negedge clk); clr[0] = 1'b1;
        @(negedge clk); clr[0] = 1'b0;
        check_eq("ovf0_clear", {56'd0, ovf0}, 64'd0);
        full[0] = 1'b0;
        send_frame(0, 32'h5A5A, 32'hC3C3, 0, 1'b1, 32, -1, -1);

        // Short left slot: error flag, no push, then recovery.
        send_frame(0, 32'hDEAD, 32'hBEEF, 0, 1'b0, 12, -1, -1);
        check_eq("ferr0_short", {63'd0, ferr0}, 64'd1);
        check_eq("ferr1_short", {63'd0, ferr1}, 64'd1);
        send_frame(0, 32'h1357, 32'h2468, 0, 1'b1, 32, -1, -1);
        check_eq("ferr0_sticky", {63'd0, ferr0}, 64'd1);
        @(negedge clk); clr[0] = 1'b1;
        @(negedge clk); clr[0] = 1'b0;
        check_eq("ferr0_clear", {63'd0, ferr0}, 64'd0);

        // Enable raised mid-left slot: partial frame dropped.
        en[0] = 1'b0;
        repeat (3) @(negedge clk);
        send_frame(0, 32'h1111, 32'h2222, 0, 1'b0, 32, 10, -1);
        send_frame(0, 32'h3333, 32'h4444, 0, 1'b1, 32, -1, -1);

        // Reset mid-right slot: that frame is lost, next complete frame pushes.
        send_frame(0, 32'h5555, 32'h6666, 0, 1'b0, 32, -1, 5);
        check_eq("mid_rst_data", {32'd0, if0.data_sig}, 64'd0);
        check_eq("mid_rst_ovf", {56'd0, ovf0}, 64'd0);
        send_frame(0, 32'h7777, 32'h8888, 0, 1'b1, 32, -1, -1);

        // 24-bit words, left channel on LRCK low.
        en[1] = 1'b1;
        send_frame(1, 32'h800001, 32'h7FFFFE, 0, 1'b1, 32, -1, -1);
        send_frame(1, 32'h123456, 32'hABCDEF, 0, 1'b1, 32, -1, -1);
        check_eq("ferr2_clean", {63'd0, ferr2}, 64'd0);

        repeat (40) @(negedge clk);
        check_eq("q0_drained", 64'(q0.size()), 64'd0);
        check_eq("q1_drained", 64'(q1.size()), 64'd0);
        check_eq("q2_drained", 64'(q2.size()), 64'd0);
        check_eq("ovf2_idle", {56'd0, ovf2}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
        $finish;
    end

endmodule
